// File: rtl/vliw_scoreboard.sv
// Register scoreboard for a VLIW issue stage: tracks outstanding multi-cycle writes per
// register and holds issue packets that carry RAW, WAW or intra-packet destination hazards.
module vliw_scoreboard #(
  parameter int NUM_LANES = 4,
  parameter int NUM_REGS  = 32,
  parameter int REG_AW    = 5,
  parameter int LAT_W     = 5,
  parameter int BYPASS    = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue_valid,
  output logic                            issue_ready,
  input  logic [NUM_LANES-1:0]            dst_valid,
  input  logic [NUM_LANES*REG_AW-1:0]     dst_addr,
  input  logic [NUM_LANES*LAT_W-1:0]      dst_lat,
  input  logic [2*NUM_LANES-1:0]          src_valid,
  input  logic [2*NUM_LANES*REG_AW-1:0]   src_addr,
  output logic [NUM_REGS-1:0]             pending,
  output logic [NUM_REGS-1:0]             retire,
  output logic [15:0]                     stall_cnt
);

  localparam int ASPACE = 1 << REG_AW;

  logic [LAT_W-1:0]    count     [NUM_REGS];
  logic [LAT_W-1:0]    count_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] pending_nxt;
  logic [ASPACE-1:0]   busy;
  logic                hazard;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    retire = '0;
    for (int r = 0; r < NUM_REGS; r++)
      retire[r] = pending[r] && (count[r] == LAT_W'(1));
  end

  // Busy over the full address space; register 0 and out-of-range addresses are never busy.
  always_comb begin
    busy = '0;
    for (int r = 1; r < NUM_REGS && r < ASPACE; r++)
      busy[r] = pending[r] && !((BYPASS != 0) && retire[r]);
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 2*NUM_LANES; i++)
      if (src_valid[i] && busy[src_addr[i*REG_AW +: REG_AW]]) hazard = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (dst_valid[i] && busy[dst_addr[i*REG_AW +: REG_AW]]) hazard = 1'b1;
      for (int j = i + 1; j < NUM_LANES; j++)
        if (dst_valid[i] && dst_valid[j] &&
            (dst_addr[i*REG_AW +: REG_AW] == dst_addr[j*REG_AW +: REG_AW]) &&
            (dst_addr[i*REG_AW +: REG_AW] != '0))
          hazard = 1'b1;
    end
  end

  assign issue_ready = issue_valid && !rst && !hazard;

  // Age every outstanding write, then overlay newly accepted loads so a new load wins.
  always_comb begin
    pending_nxt = pending;
    count_nxt   = count;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (pending[r]) begin
        if (count[r] > LAT_W'(1)) begin
          count_nxt[r] = count[r] - LAT_W'(1);
        end else begin
          pending_nxt[r] = 1'b0;
          count_nxt[r]   = '0;
        end
      end
    end
    if (issue_ready) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (dst_valid[i]) begin
          for (int r = 1; r < NUM_REGS; r++) begin
            if (dst_addr[i*REG_AW +: REG_AW] == REG_AW'(r)) begin
              pending_nxt[r] = 1'b1;
              count_nxt[r]   = (dst_lat[i*LAT_W +: LAT_W] == '0) ? LAT_W'(1)
                                                                 : dst_lat[i*LAT_W +: LAT_W];
            end
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      stall_cnt <= '0;
      // NOTE: the counter array is cleared too so a discarded write leaves no stale latency behind.
      for (int r = 0; r < NUM_REGS; r++) count[r] <= '0;
    end else begin
      pending <= pending_nxt;
      count   <= count_nxt;
      if (issue_valid && !issue_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vliw_scoreboard.sv
// Directed bench for vliw_scoreboard: one BYPASS=0 and one BYPASS=1 instance share stimulus.
module tb_vliw_scoreboard;

  localparam int NL = 4;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int LW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [NL-1:0]     dst_valid;
  logic [NL*AW-1:0]  dst_addr;
  logic [NL*LW-1:0]  dst_lat;
  logic [2*NL-1:0]   src_valid;
  logic [2*NL*AW-1:0] src_addr;
  logic              rdy0, rdy1;
  logic [NR-1:0]     pend0, pend1, ret0, ret1;
  logic [15:0]       sc0, sc1;
  logic              saw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vliw_scoreboard #(.NUM_LANES(NL), .NUM_REGS(NR), .REG_AW(AW), .LAT_W(LW), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(rdy0),
    .dst_valid(dst_valid), .dst_addr(dst_addr), .dst_lat(dst_lat),
    .src_valid(src_valid), .src_addr(src_addr),
    .pending(pend0), .retire(ret0), .stall_cnt(sc0)
  );

  vliw_scoreboard #(.NUM_LANES(NL), .NUM_REGS(NR), .REG_AW(AW), .LAT_W(LW), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(rdy1),
    .dst_valid(dst_valid), .dst_addr(dst_addr), .dst_lat(dst_lat),
    .src_valid(src_valid), .src_addr(src_addr),
    .pending(pend1), .retire(ret1), .stall_cnt(sc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_pkt();
    issue_valid = 1'b0;
    dst_valid   = '0;
    dst_addr    = '0;
    dst_lat     = '0;
    src_valid   = '0;
    src_addr    = '0;
  endtask

  task automatic set_dst(input int lane, input int a, input int l);
    issue_valid                = 1'b1;
    dst_valid[lane]            = 1'b1;
    dst_addr[lane*AW +: AW]    = AW'(a);
    dst_lat[lane*LW +: LW]     = LW'(l);
  endtask

  task automatic set_src(input int idx, input int a);
    issue_valid              = 1'b1;
    src_valid[idx]           = 1'b1;
    src_addr[idx*AW +: AW]   = AW'(a);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_pkt();
    rst = 1'b1;
    set_dst(0, 4, 2);
    next(); #1;
    check("rst_ready0", 32'(rdy0), 32'd0);
    check("rst_ready1", 32'(rdy1), 32'd0);
    next(); rst = 1'b0; clear_pkt(); #1;
    check("rst_pending", pend0, 32'd0);
    check("rst_retire", ret0, 32'd0);
    check("rst_stall0", 32'(sc0), 32'd0);
    check("rst_stall1", 32'(sc1), 32'd0);

    // Single write r5, latency 3
    next(); set_dst(0, 5, 3); #1;
    check("l3_ready", 32'(rdy0), 32'd1);
    next(); clear_pkt(); #1;
    check("l3_c1_pend", pend0, 32'(1) << 5);
    check("l3_c1_ret", ret0, 32'd0);
    next(); #1;
    check("l3_c2_pend", pend0, 32'(1) << 5);
    check("l3_c2_ret", ret0, 32'd0);
    next(); #1;
    check("l3_c3_pend", pend0, 32'(1) << 5);
    check("l3_c3_ret", ret0, 32'(1) << 5);
    next(); #1;
    check("l3_c4_pend", pend0, 32'd0);
    check("l3_c4_ret", ret0, 32'd0);

    // RAW on r5 with and without bypass
    next(); set_dst(0, 5, 2); #1;
    check("raw_c0_rdy0", 32'(rdy0), 32'd1);
    check("raw_c0_rdy1", 32'(rdy1), 32'd1);
    next(); clear_pkt(); set_src(3, 5); #1;
    check("raw_c1_rdy0", 32'(rdy0), 32'd0);
    check("raw_c1_rdy1", 32'(rdy1), 32'd0);
    next(); #1;
    check("raw_c2_rdy0", 32'(rdy0), 32'd0);
    check("raw_c2_rdy1", 32'(rdy1), 32'd1);
    next(); #1;
    check("raw_c3_rdy0", 32'(rdy0), 32'd1);
    next(); clear_pkt(); #1;
    check("raw_stall0", 32'(sc0), 32'd2);
    check("raw_stall1", 32'(sc1), 32'd1);

    // Latency 0 behaves as latency 1
    next(); set_dst(2, 6, 0); #1;
    next(); clear_pkt(); #1;
    check("l0_c1_pend", pend0, 32'(1) << 6);
    check("l0_c1_ret", ret0, 32'(1) << 6);
    next(); #1;
    check("l0_c2_pend", pend0, 32'd0);

    // Two lanes, different latencies
    next(); set_dst(1, 3, 1); set_dst(3, 10, 2); #1;
    check("ml_ready", 32'(rdy0), 32'd1);
    next(); clear_pkt(); #1;
    check("ml_c1_pend", pend0, (32'(1) << 3) | (32'(1) << 10));
    check("ml_c1_ret", ret0, 32'(1) << 3);
    next(); #1;
    check("ml_c2_pend", pend0, 32'(1) << 10);
    check("ml_c2_ret", ret0, 32'(1) << 10);
    next(); #1;
    check("ml_c3_pend", pend0, 32'd0);

    // Intra-packet duplicate destination stalls and changes nothing
    next(); set_dst(0, 7, 4); set_dst(2, 7, 4); #1;
    check("dup_ready", 32'(rdy0), 32'd0);
    next(); clear_pkt(); #1;
    check("dup_pend", pend0, 32'd0);

    // Register 0 everywhere is accepted and never pending
    next();
    for (int i = 0; i < NL; i++) set_dst(i, 0, 5);
    for (int i = 0; i < 2*NL; i++) set_src(i, 0);
    #1;
    check("r0_ready", 32'(rdy0), 32'd1);
    next(); clear_pkt(); #1;
    check("r0_pend", pend0, 32'd0);

    // Invalid lanes/operands ignored; then WAW and RAW against r7 (pending c1..c4)
    next(); set_dst(0, 7, 4); dst_addr[2*AW +: AW] = AW'(7); src_addr[5*AW +: AW] = AW'(7); #1;
    check("inv_ready", 32'(rdy0), 32'd1);
    next(); clear_pkt(); set_dst(1, 7, 1); #1;
    check("waw_ready0", 32'(rdy0), 32'd0);
    check("waw_ready1", 32'(rdy1), 32'd0);
    next(); clear_pkt(); issue_valid = 1'b1; src_addr[0 +: AW] = AW'(7); #1;
    check("srcinv_ready", 32'(rdy0), 32'd1);
    next(); clear_pkt(); set_src(0, 7); #1;
    check("raw7_ready1", 32'(rdy1), 32'd0);
    next(); clear_pkt(); #1;
    check("r7_c4_ret", ret0, 32'(1) << 7);
    next(); #1;
    check("r7_c5_pend", pend0, 32'd0);
    check("mid_stall0", 32'(sc0), 32'd5);
    check("mid_stall1", 32'(sc1), 32'd4);

    // Retire and new load to the same register in one cycle
    next(); set_dst(0, 12, 1); #1;
    next(); clear_pkt(); set_dst(0, 12, 3); #1;
    check("nl_c1_rdy0", 32'(rdy0), 32'd0);
    check("nl_c1_rdy1", 32'(rdy1), 32'd1);
    next(); clear_pkt(); #1;
    check("nl_c2_pend1", pend1, 32'(1) << 12);
    check("nl_c2_ret1", ret1, 32'd0);
    check("nl_c2_pend0", pend0, 32'd0);
    next(); #1;
    check("nl_c3_pend1", pend1, 32'(1) << 12);
    next(); #1;
    check("nl_c4_ret1", ret1, 32'(1) << 12);
    next(); #1;
    check("nl_c5_pend1", pend1, 32'd0);

    // Reset mid-flight discards r9 (latency 31)
    saw = 1'b0;
    next(); set_dst(0, 9, 31); #1;
    check("rm_ready", 32'(rdy0), 32'd1);
    for (int c = 1; c <= 9; c++) begin
      next(); clear_pkt(); #1;
      saw = saw | ret0[9] | ret1[9];
    end
    check("rm_c9_pend", pend0, 32'(1) << 9);
    next(); rst = 1'b1; set_src(0, 9); #1;
    check("rm_c10_ready", 32'(rdy0), 32'd0);
    next(); rst = 1'b0; clear_pkt(); #1;
    check("rm_c11_pend0", pend0, 32'd0);
    check("rm_c11_pend1", pend1, 32'd0);
    check("rm_c11_ret", ret0, 32'd0);
    check("rm_stall0", 32'(sc0), 32'd0);
    check("rm_stall1", 32'(sc1), 32'd0);
    for (int c = 0; c < 40; c++) begin
      next();
      saw = saw | ret0[9] | ret1[9];
    end
    check("rm_no_retire", 32'(saw), 32'd0);

    // Permanent hazard: stall counter saturates
    next(); set_dst(0, 20, 3); set_dst(1, 20, 3); #1;
    repeat (65534) next();
    check("sat_fffe", 32'(sc0), 32'h0000FFFE);
    next();
    check("sat_ffff", 32'(sc0), 32'h0000FFFF);
    repeat (4465) next();
    check("sat_hold0", 32'(sc0), 32'h0000FFFF);
    check("sat_hold1", 32'(sc1), 32'h0000FFFF);
    check("sat_ready", 32'(rdy0), 32'd0);
    clear_pkt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
